// File: rtl/cm_arb_pkg.sv
// rtl/cm_arb_pkg.sv - shared state encoding and helpers for the priority/round-robin arbiter
package cm_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/cm_arb_rr_pick.sv
// rtl/cm_arb_rr_pick.sv - combinational round-robin pick: rotate by ptr, find first, un-rotate
module cm_arb_rr_pick #(
  parameter int REQ_NUM  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [REQ_NUM-1:0]  cand,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [REQ_NUM-1:0]  pick,
  output logic [ID_WIDTH-1:0] pick_id,
  output logic                pick_vld
);

  logic [REQ_NUM-1:0] rot;
  int                 first;

  always_comb begin
    rot      = '0;
    first    = 0;
    pick     = '0;
    pick_id  = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < REQ_NUM; k++) begin
      rot[k] = cand[(k + int'(ptr)) % REQ_NUM];
    end
    // Scan downward so the lowest set bit of the rotated vector is the one kept.
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      if (rot[k]) begin
        first    = k;
        pick_vld = 1'b1;
      end
    end
    if (pick_vld) begin
      pick_id       = ID_WIDTH'((first + int'(ptr)) % REQ_NUM);
      pick[pick_id] = 1'b1;
    end
  end

endmodule

// File: rtl/cm_arb_pri_rr.sv
// rtl/cm_arb_pri_rr.sv - priority-filtered round-robin grant controller with bounded lock hold
module cm_arb_pri_rr
  import cm_arb_pkg::*;
#(
  parameter  int REQ_NUM   = 4,
  parameter  int PRI_WIDTH = 2,
  parameter  int HOLD_MAX  = 8,
  localparam int ID_WIDTH  = clog2(REQ_NUM)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [REQ_NUM-1:0]           req,
  input  logic [PRI_WIDTH*REQ_NUM-1:0] pri,
  input  logic [REQ_NUM-1:0]           lock,
  input  logic                         done,
  output logic [REQ_NUM-1:0]           gnt,
  output logic                         gnt_vld,
  output logic [ID_WIDTH-1:0]          gnt_id,
  output logic [PRI_WIDTH-1:0]         gnt_pri
);

  localparam int HOLD_W = (HOLD_MAX == 0) ? 1 : clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

  arb_state_t          state;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [HOLD_W-1:0]   hold_cnt;

  logic [REQ_NUM-1:0]   arb_req;
  logic [REQ_NUM-1:0]   cand;
  logic [PRI_WIDTH-1:0] pmax;
  logic [PRI_WIDTH-1:0] owner_pri;
  logic                 owner_req;
  logic                 owner_lock;
  logic                 release_evt;
  logic                 hold_ok;
  logic [ID_WIDTH-1:0]  next_ptr;
  logic [ID_WIDTH-1:0]  arb_ptr;
  logic [REQ_NUM-1:0]   win;
  logic [ID_WIDTH-1:0]  win_id;
  logic                 win_vld;

  assign owner_req   = |(req & gnt);
  assign owner_lock  = |(lock & gnt);
  assign release_evt = done | ~owner_req;
  assign hold_ok     = (HOLD_MAX == 0) || (hold_cnt < HOLD_LIM);
  assign next_ptr    = (gnt_id == ID_WIDTH'(REQ_NUM - 1)) ? '0 : gnt_id + ID_WIDTH'(1);

  // While busy the current owner sits out the handover arbitration, which starts past it.
  assign arb_req = (state == ARB_BUSY) ? (req & ~gnt) : req;
  assign arb_ptr = (state == ARB_BUSY) ? next_ptr : rr_ptr;

  always_comb begin
    pmax      = '0;
    cand      = '0;
    owner_pri = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (arb_req[i] && (pri[i*PRI_WIDTH +: PRI_WIDTH] > pmax)) pmax = pri[i*PRI_WIDTH +: PRI_WIDTH];
      if (gnt[i]) owner_pri = pri[i*PRI_WIDTH +: PRI_WIDTH];
    end
    for (int i = 0; i < REQ_NUM; i++) begin
      cand[i] = arb_req[i] && (pri[i*PRI_WIDTH +: PRI_WIDTH] == pmax);
    end
  end

  cm_arb_rr_pick #(
    .REQ_NUM (REQ_NUM),
    .ID_WIDTH(ID_WIDTH)
  ) u_pick (
    .cand    (cand),
    .ptr     (arb_ptr),
    .pick    (win),
    .pick_id (win_id),
    .pick_vld(win_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_vld  <= 1'b0;
      gnt_id   <= '0;
      gnt_pri  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (win_vld) begin
            state    <= ARB_BUSY;
            gnt      <= win;
            gnt_vld  <= 1'b1;
            gnt_id   <= win_id;
            gnt_pri  <= pmax;
            hold_cnt <= '0;
          end
        end
        ARB_BUSY: begin
          if (release_evt) begin
            if (owner_lock && owner_req && hold_ok) begin
              if (hold_cnt != {HOLD_W{1'b1}}) hold_cnt <= hold_cnt + HOLD_W'(1);
            end else begin
              rr_ptr   <= next_ptr;
              hold_cnt <= '0;
              if (win_vld) begin
                gnt     <= win;
                gnt_id  <= win_id;
                gnt_pri <= pmax;
              end else if (owner_req) begin
                // Sole requester left: the unmasked arbitration can only pick the owner again.
                gnt_pri <= owner_pri;
              end else begin
                state   <= ARB_IDLE;
                gnt     <= '0;
                gnt_vld <= 1'b0;
                gnt_id  <= '0;
                gnt_pri <= '0;
              end
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
